// File: rtl/glitch_filter_edge_counter_if.sv
// glitch_filter_edge_counter_if: raw input, debounced level, edge count and event handshake.
// GLITCH_CNT_EN adds the glitch_cnt rejected-window counter.
interface glitch_filter_edge_counter_if #(parameter int CNT_W = 8);
   logic             din;
   logic             filt;
   logic [CNT_W-1:0] rise_cnt;
   logic             evt_valid;
   logic             evt_ready;
   logic             evt_overrun;
`ifdef GLITCH_CNT_EN
   logic [7:0]       glitch_cnt;
   modport master(input din, evt_ready, output filt, rise_cnt, evt_valid, evt_overrun, glitch_cnt);
   modport slave(output din, evt_ready, input filt, rise_cnt, evt_valid, evt_overrun, glitch_cnt);
`else
   modport master(input din, evt_ready, output filt, rise_cnt, evt_valid, evt_overrun);
   modport slave(output din, evt_ready, input filt, rise_cnt, evt_valid, evt_overrun);
`endif
endinterface

// File: rtl/glitch_filter_edge_counter.sv
// glitch_filter_edge_counter: synchronise, debounce, count rises and report them as events.
// GLITCH_CNT_EN adds a saturating count of rejected confirm windows.
module glitch_filter_edge_counter #(
   parameter int FILTER_LEN = 4,
   parameter int CNT_W      = 8
) (
   input logic                         clk,
   input logic                         rst,
   glitch_filter_edge_counter_if.master bus
);
   // bit 1 of the state is the debounced level
   localparam logic [1:0] STABLE_LOW   = 2'd0;
   localparam logic [1:0] CONFIRM_HIGH = 2'd1;
   localparam logic [1:0] STABLE_HIGH  = 2'd2;
   localparam logic [1:0] CONFIRM_LOW  = 2'd3;
   logic             s1_q, s2_q;
   logic [1:0]       state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
   logic             evt_valid_q, evt_valid_d, overrun_q, overrun_d;
   logic             rise, rej;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise    = 1'b0;
      rej     = 1'b0;
      case (state_q)
         STABLE_LOW: if (s2_q) begin
            state_d = CONFIRM_HIGH;
            cnt_d   = 8'd1;
         end
         CONFIRM_HIGH: if (!s2_q) begin
            state_d = STABLE_LOW;
            rej     = 1'b1;
         end else if (cnt_q == 8'(FILTER_LEN - 1)) begin
            state_d = STABLE_HIGH;
            rise    = 1'b1;
         end else cnt_d = cnt_q + 8'd1;
         STABLE_HIGH: if (!s2_q) begin
            state_d = CONFIRM_LOW;
            cnt_d   = 8'd1;
         end
         CONFIRM_LOW: if (s2_q) begin
            state_d = STABLE_HIGH;
            rej     = 1'b1;
         end else if (cnt_q == 8'(FILTER_LEN - 1)) state_d = STABLE_LOW;
         else cnt_d = cnt_q + 8'd1;
      endcase
   end
   // a rise while an unaccepted event is pending is dropped and flagged
   assign evt_valid_d = rise | (evt_valid_q & ~bus.evt_ready);
   assign overrun_d   = overrun_q | (rise & evt_valid_q & ~bus.evt_ready);
   assign rise_cnt_d  = rise_cnt_q + CNT_W'(rise);
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         state_q     <= STABLE_LOW;
         cnt_q       <= 8'd0;
         rise_cnt_q  <= '0;
         evt_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         s1_q        <= bus.din;
         s2_q        <= s1_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rise_cnt_q  <= rise_cnt_d;
         evt_valid_q <= evt_valid_d;
         overrun_q   <= overrun_d;
      end
   end
   assign bus.filt        = state_q[1];
   assign bus.rise_cnt    = rise_cnt_q;
   assign bus.evt_valid   = evt_valid_q;
   assign bus.evt_overrun = overrun_q;
`ifdef GLITCH_CNT_EN
   logic [7:0] glitch_q, glitch_d;
   assign glitch_d = glitch_q + 8'((rej && glitch_q != 8'hff) ? 1 : 0);
   always_ff @(posedge clk) glitch_q <= rst ? 8'd0 : glitch_d;
   assign bus.glitch_cnt = glitch_q;
`else
   logic unused_rej;
   assign unused_rej = rej;
`endif
endmodule

// File: tb/tb_glitch_filter_edge_counter.sv
// tb_glitch_filter_edge_counter: scoreboard bench with a run-length reference model.
module tb_glitch_filter_edge_counter;
   localparam int FL = 4;
   localparam int CW = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   glitch_filter_edge_counter_if #(.CNT_W(CW)) bus();
   glitch_filter_edge_counter #(.FILTER_LEN(FL), .CNT_W(CW)) dut(.clk(clk), .rst(rst), .bus(bus));
   typedef struct {
      logic          filt;
      logic [CW-1:0] rc;
      logic          v;
      logic          ov;
      logic [7:0]    g;
   } exp_t;
   exp_t q[$];
   exp_t e;
   int checks = 0;
   int failures = 0;
   bit m_s1, m_s2, m_filt, m_v, m_ov;
   int m_run, m_rc, m_g;
   function automatic void chk(string n, logic [31:0] a, logic [31:0] x);
      checks++;
      if (a !== x) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, x);
      end
   endfunction
   // reference: the level flips after FL consecutive synchronised samples that differ from it
   function automatic bit will_rise();
      return !m_filt && m_s2 && m_run == FL - 1;
   endfunction
   task automatic step(input bit d, input bit rdy, input bit r);
      bit rise;
      @(negedge clk);
      bus.din = d;
      bus.evt_ready = rdy;
      rst = r;
      if (r) begin
         {m_s1, m_s2, m_filt, m_v, m_ov} = '0;
         m_run = 0; m_rc = 0; m_g = 0;
      end else begin
         rise = 1'b0;
         if (m_s2 != m_filt) begin
            m_run++;
            if (m_run == FL) begin
               m_filt = !m_filt;
               m_run = 0;
               rise = m_filt;
            end
         end else begin
            if (m_run > 0 && m_g < 255) m_g++;
            m_run = 0;
         end
         if (rise) begin
            if (m_v && !rdy) m_ov = 1'b1;
            m_v = 1'b1;
            m_rc = (m_rc + 1) % (1 << CW);
         end else if (m_v && rdy) m_v = 1'b0;
         m_s2 = m_s1;
         m_s1 = d;
      end
      q.push_back('{m_filt, CW'(m_rc), m_v, m_ov, 8'(m_g)});
   endtask
   task automatic pulse(input int hi, input int lo, input bit rdy);
      for (int i = 0; i < hi; i++) step(1'b1, rdy, 1'b0);
      for (int i = 0; i < lo; i++) step(1'b0, rdy, 1'b0);
   endtask
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("filt", 32'(bus.filt), 32'(e.filt));
         chk("rise_cnt", 32'(bus.rise_cnt), 32'(e.rc));
         chk("evt_valid", 32'(bus.evt_valid), 32'(e.v));
         chk("evt_overrun", 32'(bus.evt_overrun), 32'(e.ov));
`ifdef GLITCH_CNT_EN
         chk("glitch_cnt", 32'(bus.glitch_cnt), 32'(e.g));
`endif
      end
   end
   initial begin
      bus.din = 1'b0;
      bus.evt_ready = 1'b0;
      step(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      pulse(3, 8, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      pulse(8, 8, 1'b0);
      pulse(8, 8, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      pulse(8, 8, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, will_rise(), 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 255; i++) pulse(8, 8, 1'b1);
      pulse(8, 8, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         bit d;
         int len;
         d = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 7);
         for (int j = 0; j < len; j++) step(d, 1'($urandom_range(0, 1)), $urandom_range(0, 199) == 0);
      end
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expected entries left, required 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
